// File: rtl/edge_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_evt_pkg
// Description : Shared types and default sizing for the edge event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_evt_pkg;

  // Default channel count and dropped-event counter width
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;

  // Arbiter FSM: IDLE searches for a pending channel, OFFER holds one event
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/edge_evt_channel.sv
`default_nettype none
// ============================================================================
// Module      : edge_evt_channel
// Description : One monitored channel - edge detect, pending/type storage and
//               drop strobe for an edge arriving while an event is held.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_evt_channel (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_clr,
  output logic o_pending,
  output logic o_rise,
  output logic o_drop
);

  logic r_prev;
  logic r_pending;
  logic r_rise;
  logic w_rise;
  logic w_fall;
  logic w_edge;

  assign w_rise = i_sig & ~r_prev & i_rise_en;
  assign w_fall = ~i_sig & r_prev & i_fall_en;
  assign w_edge = w_rise | w_fall;

  // An edge is lost only if the held event is not leaving this same cycle
  assign o_drop    = w_edge & r_pending & ~i_clr;
  assign o_pending = r_pending;
  assign o_rise    = r_rise;

  // Track previous level and capture new events; a completing grant frees the slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_prev <= i_sig;
      if (w_edge && (!r_pending || i_clr)) begin
        r_pending <= 1'b1;
        r_rise    <= w_rise;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Per-channel edge capture with round-robin arbitration onto a
//               single valid/ready event port and a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         sig_i,
  input  logic [NUM_CH-1:0]         rise_en_i,
  input  logic [NUM_CH-1:0]         fall_en_i,
  input  logic                      evt_ready_i,
  output logic                      evt_valid_o,
  output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
  output logic                      evt_rise_o,
  output logic [NUM_CH-1:0]         pending_o,
  output logic [CNT_W-1:0]          drop_cnt_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  // Wide enough to add up to 16 simultaneous drops without overflow
  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_ch_nxt;
  logic              r_rise;
  logic              w_rise_nxt;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_rr_nxt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_type;
  logic [NUM_CH-1:0] w_drop;
  logic [NUM_CH-1:0] w_clr;
  logic              w_hs;
  logic              w_found;
  logic [CH_W-1:0]   w_sel;
  logic [CH_W-1:0]   w_idx;
  logic [SUM_W-1:0]  w_drop_sum;
  logic [SUM_W-1:0]  w_cnt_sum;

  assign w_hs = (r_state == OFFER) && evt_ready_i;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_clr[gi] = w_hs && (r_ch == CH_W'(gi));
    edge_evt_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_sig     (sig_i[gi]),
      .i_rise_en (rise_en_i[gi]),
      .i_fall_en (fall_en_i[gi]),
      .i_clr     (w_clr[gi]),
      .o_pending (w_pending[gi]),
      .o_rise    (w_type[gi]),
      .o_drop    (w_drop[gi])
    );
  end

  // Circular search for the first pending channel at or after the rr pointer
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, hold in OFFER until the handshake
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_rise_nxt  = r_rise;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OFFER;
          w_ch_nxt    = w_sel;
          w_rise_nxt  = w_type[w_sel];
        end
      end
      OFFER: begin
        if (evt_ready_i) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, offered event and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_rise   <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch     <= w_ch_nxt;
      r_rise   <= w_rise_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Count the channels dropping this cycle and add to the running total
  always_comb begin
    w_drop_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_drop_sum = w_drop_sum + SUM_W'(w_drop[i]);
    end
    w_cnt_sum = SUM_W'(r_drop_cnt) + w_drop_sum;
  end

  // Saturating dropped-event counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_cnt_sum > CNT_MAX) begin
      r_drop_cnt <= {CNT_W{1'b1}};
    end else begin
      r_drop_cnt <= w_cnt_sum[CNT_W-1:0];
    end
  end

  assign evt_valid_o = (r_state == OFFER);
  assign evt_ch_o    = r_ch;
  assign evt_rise_o  = r_rise;
  assign pending_o   = w_pending;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Directed self-checking bench for edge_event_arbiter, with a
//               second narrow-counter instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] sig_i;
  logic [3:0] rise_en_i;
  logic [3:0] fall_en_i;
  logic       evt_ready_i;

  logic       evt_valid_o;
  logic [1:0] evt_ch_o;
  logic       evt_rise_o;
  logic [3:0] pending_o;
  logic [7:0] drop_cnt_o;

  logic       v2;
  logic [1:0] ch2;
  logic       r2;
  logic [3:0] p2;
  logic [1:0] d2;

  int n_cmp = 0;
  int n_err = 0;

  edge_event_arbiter #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sig_i(sig_i), .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i), .evt_ready_i(evt_ready_i), .evt_valid_o(evt_valid_o),
    .evt_ch_o(evt_ch_o), .evt_rise_o(evt_rise_o), .pending_o(pending_o),
    .drop_cnt_o(drop_cnt_o)
  );

  edge_event_arbiter #(.NUM_CH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sig_i(sig_i), .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i), .evt_ready_i(evt_ready_i), .evt_valid_o(v2),
    .evt_ch_o(ch2), .evt_rise_o(r2), .pending_o(p2), .drop_cnt_o(d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; sig_i = '0; rise_en_i = '0; fall_en_i = '0; evt_ready_i = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b0; sig_i = 4'hF; rise_en_i = 4'hF; fall_en_i = 4'hF; evt_ready_i = 1'b1;
    cyc(3);
    n_cmp++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", evt_valid_o); end
    n_cmp++; if (evt_ch_o !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", evt_ch_o); end
    n_cmp++; if (evt_rise_o !== 1'b0) begin n_err++; $display("FAIL reset_rise: got %0b want 0", evt_rise_o); end
    n_cmp++; if (pending_o !== 4'h0) begin n_err++; $display("FAIL reset_pending: got %0h want 0", pending_o); end
    n_cmp++; if (drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_rise_ch2();
    do_reset();
    rise_en_i = 4'hF; evt_ready_i = 1'b1;
    sig_i = 4'b0100;
    cyc(1);
    n_cmp++; if (pending_o !== 4'b0100) begin n_err++; $display("FAIL rise_ch2_pend: got %0h want 4", pending_o); end
    n_cmp++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL rise_ch2_early: got %0b want 0", evt_valid_o); end
    cyc(1);
    n_cmp++; if (evt_valid_o !== 1'b1) begin n_err++; $display("FAIL rise_ch2_valid: got %0b want 1", evt_valid_o); end
    n_cmp++; if (evt_ch_o !== 2'd2) begin n_err++; $display("FAIL rise_ch2_ch: got %0d want 2", evt_ch_o); end
    n_cmp++; if (evt_rise_o !== 1'b1) begin n_err++; $display("FAIL rise_ch2_rise: got %0b want 1", evt_rise_o); end
    cyc(1);
    n_cmp++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL rise_ch2_one_cycle: got %0b want 0", evt_valid_o); end
    n_cmp++; if (pending_o !== 4'h0) begin n_err++; $display("FAIL rise_ch2_clear: got %0h want 0", pending_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rise_en_i = 4'hF; evt_ready_i = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      sig_i = 4'b1001;
      cyc(2);
      n_cmp++; if (evt_valid_o !== 1'b1 || evt_ch_o !== 2'd0) begin n_err++; $display("FAIL rr_first[%0d]: got v=%0b ch=%0d want v=1 ch=0", pass, evt_valid_o, evt_ch_o); end
      cyc(1);
      n_cmp++; if (evt_valid_o !== 1'b0 || pending_o !== 4'b1000) begin n_err++; $display("FAIL rr_gap[%0d]: got v=%0b p=%0h want v=0 p=8", pass, evt_valid_o, pending_o); end
      cyc(1);
      n_cmp++; if (evt_valid_o !== 1'b1 || evt_ch_o !== 2'd3) begin n_err++; $display("FAIL rr_second[%0d]: got v=%0b ch=%0d want v=1 ch=3", pass, evt_valid_o, evt_ch_o); end
      cyc(1);
      n_cmp++; if (evt_valid_o !== 1'b0 || pending_o !== 4'h0) begin n_err++; $display("FAIL rr_done[%0d]: got v=%0b p=%0h want v=0 p=0", pass, evt_valid_o, pending_o); end
      sig_i = 4'b0000;
      cyc(1);
    end
  endtask

  task automatic test_drop();
    do_reset();
    rise_en_i = 4'hF; fall_en_i = 4'hF; evt_ready_i = 1'b0;
    sig_i = 4'b0010;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      sig_i = (k % 2 == 0) ? 4'b0000 : 4'b0010;
      cyc(1);
    end
    n_cmp++; if (drop_cnt_o !== 8'd3) begin n_err++; $display("FAIL drop_cnt: got %0d want 3", drop_cnt_o); end
    n_cmp++; if (evt_valid_o !== 1'b1 || evt_ch_o !== 2'd1 || evt_rise_o !== 1'b1) begin n_err++; $display("FAIL drop_held: got v=%0b ch=%0d r=%0b want v=1 ch=1 r=1", evt_valid_o, evt_ch_o, evt_rise_o); end
    n_cmp++; if (pending_o !== 4'b0010) begin n_err++; $display("FAIL drop_pend: got %0h want 2", pending_o); end
    evt_ready_i = 1'b1;
    cyc(1);
    n_cmp++; if (evt_valid_o !== 1'b0 || pending_o !== 4'h0) begin n_err++; $display("FAIL drop_release: got v=%0b p=%0h want v=0 p=0", evt_valid_o, pending_o); end
  endtask

  task automatic test_saturate();
    do_reset();
    rise_en_i = 4'hF; fall_en_i = 4'hF; evt_ready_i = 1'b0;
    sig_i = 4'b0010;
    cyc(2);
    for (int k = 0; k < 5; k++) begin
      sig_i = (k % 2 == 0) ? 4'b0000 : 4'b0010;
      cyc(1);
      if (k == 2) begin
        n_cmp++; if (d2 !== 2'd3) begin n_err++; $display("FAIL sat_reach: got %0d want 3", d2); end
      end
    end
    n_cmp++; if (d2 !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", d2); end
    n_cmp++; if (drop_cnt_o !== 8'd5) begin n_err++; $display("FAIL sat_wide: got %0d want 5", drop_cnt_o); end
  endtask

  task automatic test_hs_fall();
    do_reset();
    rise_en_i = 4'hF; fall_en_i = 4'hF; evt_ready_i = 1'b0;
    sig_i = 4'b0010;
    cyc(2);
    evt_ready_i = 1'b1; sig_i = 4'b0000;
    cyc(1);
    evt_ready_i = 1'b0;
    n_cmp++; if (drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL hs_fall_nodrop: got %0d want 0", drop_cnt_o); end
    n_cmp++; if (evt_valid_o !== 1'b0 || pending_o !== 4'b0010) begin n_err++; $display("FAIL hs_fall_recap: got v=%0b p=%0h want v=0 p=2", evt_valid_o, pending_o); end
    cyc(1);
    n_cmp++; if (evt_valid_o !== 1'b1 || evt_ch_o !== 2'd1 || evt_rise_o !== 1'b0) begin n_err++; $display("FAIL hs_fall_next: got v=%0b ch=%0d r=%0b want v=1 ch=1 r=0", evt_valid_o, evt_ch_o, evt_rise_o); end
  endtask

  task automatic test_rise_after_reset();
    reset = 1'b0; sig_i = 4'b0001; rise_en_i = 4'hF; fall_en_i = 4'h0; evt_ready_i = 1'b0;
    cyc(2);
    n_cmp++; if (pending_o !== 4'h0) begin n_err++; $display("FAIL rel_inreset: got %0h want 0", pending_o); end
    reset = 1'b1;
    cyc(1);
    n_cmp++; if (pending_o !== 4'b0001) begin n_err++; $display("FAIL rel_rise_pend: got %0h want 1", pending_o); end
    rise_en_i = 4'h0;
    cyc(1);
    n_cmp++; if (evt_valid_o !== 1'b1 || evt_ch_o !== 2'd0 || evt_rise_o !== 1'b1) begin n_err++; $display("FAIL rel_en_cleared: got v=%0b ch=%0d r=%0b want v=1 ch=0 r=1", evt_valid_o, evt_ch_o, evt_rise_o); end
  endtask

  task automatic test_reset_offer();
    do_reset();
    rise_en_i = 4'hF; evt_ready_i = 1'b0;
    sig_i = 4'b0100;
    cyc(2);
    n_cmp++; if (evt_valid_o !== 1'b1 || evt_ch_o !== 2'd2) begin n_err++; $display("FAIL rst_offer_pre: got v=%0b ch=%0d want v=1 ch=2", evt_valid_o, evt_ch_o); end
    reset = 1'b0;
    cyc(1);
    n_cmp++; if (evt_valid_o !== 1'b0 || pending_o !== 4'h0 || evt_ch_o !== 2'd0) begin n_err++; $display("FAIL rst_offer_clear: got v=%0b p=%0h ch=%0d want 0 0 0", evt_valid_o, pending_o, evt_ch_o); end
    sig_i = 4'b0000; reset = 1'b1;
    cyc(3);
    n_cmp++; if (evt_valid_o !== 1'b0 || pending_o !== 4'h0) begin n_err++; $display("FAIL rst_offer_quiet: got v=%0b p=%0h want v=0 p=0", evt_valid_o, pending_o); end
  endtask

  initial begin
    reset = 1'b0; sig_i = '0; rise_en_i = '0; fall_en_i = '0; evt_ready_i = 1'b0;
    test_reset();
    test_rise_ch2();
    test_round_robin();
    test_drop();
    test_saturate();
    test_hs_fall();
    test_rise_after_reset();
    test_reset_offer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of monitored input channels (range 2..16).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the dropped-event counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset (0 = reset).
REQ-005 sig_i  input  NUM_CH  SHALL carry the level signals to monitor, synchronous to clk.
REQ-006 rise_en_i  input  NUM_CH  SHALL enable rising-edge event capture per channel.
REQ-007 fall_en_i  input  NUM_CH  SHALL enable falling-edge event capture per channel.
REQ-008 evt_ready_i  input  1  SHALL be the consumer's ready signal for the event output.
REQ-009 evt_valid_o  output  1  SHALL indicate that an event is being offered.
REQ-010 evt_ch_o  output  $clog2(NUM_CH)  SHALL give the channel index of the offered event.
REQ-011 evt_rise_o  output  1  SHALL be 1 for a rising event and 0 for a falling event.
REQ-012 pending_o  output  NUM_CH  SHALL expose the per-channel pending flags.
REQ-013 drop_cnt_o  output  CNT_W  SHALL give the saturating count of dropped events.

Function
REQ-014 Each channel SHALL register sig_i each cycle; rise = sig_i & ~prev, fall = ~sig_i & prev, each gated by its enable.
REQ-015 An enabled edge sampled at clock edge k SHALL set that channel's pending flag and its type bit after edge k.
REQ-016 An enabled edge on a channel that is already pending and not completing a handshake in the same cycle SHALL be dropped; pending and type remain unchanged.
REQ-017 An enabled edge on the channel whose handshake completes in the same cycle SHALL be captured as a new pending event, not dropped.
REQ-018 drop_cnt_o SHALL add the number of channels dropping in a cycle, saturating at 2^CNT_W-1 with no wrap.
REQ-019 The FSM SHALL have two states. In IDLE it SHALL take no action when no channel is pending. In OFFER it SHALL hold the registered event.
REQ-020 In IDLE with any flag pending, the FSM SHALL select the first pending channel at or after rr_ptr (circular search), register its index and type, and move to OFFER.
REQ-021 In OFFER, evt_valid_o SHALL be 1, and evt_ch_o and evt_rise_o SHALL stay stable until the handshake completes.
REQ-022 A handshake SHALL complete when evt_valid_o and evt_ready_i are both 1 at a clock edge. On that edge the FSM SHALL clear the granted channel's pending flag (except as in REQ-017), set rr_ptr = (granted+1) mod NUM_CH, and return to IDLE.
REQ-023 Latency SHALL be: edge sampled at clock edge k gives evt_valid_o = 1 after edge k+1 when the FSM is in IDLE with nothing else pending.
REQ-024 Maximum throughput SHALL be one event per 2 cycles.
REQ-025 evt_valid_o SHALL NOT depend combinationally on evt_ready_i.
REQ-026 Clearing an enable while the channel is pending SHALL NOT clear the pending event.

Reset
REQ-027 While reset = 0, the following SHALL be held at their reset values: prev registers 0, pending flags 0, type bits 0, rr_ptr 0, FSM IDLE, drop_cnt_o 0, evt_valid_o 0, evt_ch_o 0, evt_rise_o 0.
REQ-028 If sig_i is high at the first cycle after reset release, a rising event SHALL be generated, because prev resets to 0.
REQ-029 Reset asserted during OFFER SHALL discard the offered event; evt_valid_o SHALL be 0 after that edge.

Structure
REQ-030 Package edge_evt_pkg SHALL hold the FSM state typedef (IDLE, OFFER) and the default values of NUM_CH and CNT_W.
REQ-031 Sub-module edge_evt_channel SHALL implement one channel: prev register, edge gating, pending and type storage, and the drop strobe.
REQ-032 The top level SHALL instantiate edge_evt_channel NUM_CH times and contain the FSM, rr_ptr, output registers and the drop counter.

Verification
REQ-033 Rise on ch2 with rise_en=1111 and ready=1 -> evt_valid_o high 2 edges later with ch=2, rise=1, for 1 cycle; pending_o[2] back to 0.
REQ-034 Rises on ch0 and ch3 in the same cycle with ready=1 -> events ch0 then ch3, valid 2 cycles apart; a further ch0+ch3 pair -> ch0 then ch3 again (rr_ptr wraps to 0).
REQ-035 ready=0, ch1 pending, then 3 more enabled edges on ch1 -> drop_cnt_o = 3; the held event is unchanged.
REQ-036 CNT_W=2, 5 drops -> drop_cnt_o = 3 and stays 3.
REQ-037 Completing handshake on ch1 while a fall occurs on ch1 in the same cycle -> no drop; the next event is ch1 with rise=0.
REQ-038 Reset=0 during OFFER for ch2 -> evt_valid_o = 0 and pending_o = 0 after 1 edge; release with sig_i=0 -> no event.
